spi_eeprom_responder: RTL and testbench

// - SPI mode-0 slave that emulates a 95xxx-style serial EEPROM (READ/WRITE/WREN/WRDI/RDSR) over an external byte-wide memory port.
// - Other end of chip_top's SPI boot-read master; lets a chip be booted from on-board RAM or FPGA fabric instead of a discrete EEPROM.
// - SPI pins are oversampled in the system clk domain; no logic is clocked by spi_clk.

---
 rtl/spi_eeprom_pkg.sv | 32 +++
 rtl/spi_in_sync.sv | 29 ++
 rtl/spi_eeprom_responder.sv | 267 ++++++++++++++++++++++++++
 tb/tb_spi_eeprom_responder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, FSM encoding and helpers for the SPI EEPROM responder.
package spi_eeprom_pkg;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_RDATA,
        ST_WDATA,
        ST_STAT,
        ST_IGNORE
    } state_t;

    // Pending write-enable-latch update, committed at ss deassert
    typedef enum logic [1:0] {
        WOP_NONE,
        WOP_SET,
        WOP_CLR
    } wel_op_t;

    // Status register image: WIP is always 0, WEL in bit 1
    function automatic logic [7:0] status_byte(input logic wel);
        return {6'b0, wel, 1'b0};
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Multi-stage synchronizer with rise/fall pulses for one asynchronous input.
// Ports: clk, reset (async active-low), d (async input),
//        rise/fall (1-clk pulses derived from the last two sync stages).
module spi_in_sync #(
    parameter int unsigned SYNC_STG = 2,
    parameter logic        RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic rise,
    output logic fall
);

    // s[0] captures the pin; s[SYNC_STG-1] is the oldest stage
    logic [SYNC_STG-1:0] s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s <= {SYNC_STG{RST_VAL}};
        end else begin
            s <= {s[SYNC_STG-2:0], d};
        end
    end

    assign rise =  s[SYNC_STG-2] & ~s[SYNC_STG-1];
    assign fall = ~s[SYNC_STG-2] &  s[SYNC_STG-1];

endmodule

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 slave emulating a 95xxx serial EEPROM over a byte-wide memory port.
// Ports: clk, reset (async active-low); spi_clk/ss/mosi/miso/miso_oe SPI side;
//        mem_addr/mem_rd/mem_rdata/mem_wr/mem_wdata memory side; wel status latch.
module spi_eeprom_responder
    import spi_eeprom_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned MEM_DEPTH = 65536,
    parameter int unsigned SYNC_STG  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_clk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    output logic              wel
);

    localparam int unsigned CNT_W = $clog2(ADDR_W > 8 ? ADDR_W : 8);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

    function automatic logic [ADDR_W-1:0] addr_mod(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] e;
        e = {1'b0, a} % DEPTH;
        return e[ADDR_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        if (({1'b0, a} + (ADDR_W+1)'(1)) >= DEPTH) begin
            return '0;
        end
        return a + ADDR_W'(1);
    endfunction

    // Pin synchronization
    logic sck_rise, sck_fall, ss_rise, ss_fall;
    logic [SYNC_STG-1:0] mosi_s;
    logic mosi_bit;

    spi_in_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b0)) u_sync_sck (
        .clk(clk), .reset(reset), .d(spi_clk), .rise(sck_rise), .fall(sck_fall)
    );

    spi_in_sync #(.SYNC_STG(SYNC_STG), .RST_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset(reset), .d(ss), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mosi_s <= '0;
        end else begin
            mosi_s <= {mosi_s[SYNC_STG-2:0], mosi};
        end
    end

    assign mosi_bit = mosi_s[SYNC_STG-1];

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [6:0]        rx, rx_nxt;
    logic [7:0]        tx, tx_nxt;
    logic [ADDR_W-2:0] addr_sr, addr_sr_nxt;
    logic              is_rd, is_rd_nxt;
    logic              rd_d;
    wel_op_t           wop, wop_nxt;
    logic              extra, extra_nxt;
    logic              wrote, wrote_nxt;
    logic              miso_nxt, miso_oe_nxt, mem_rd_nxt, mem_wr_nxt, wel_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [7:0]        mem_wdata_nxt;

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rx        <= '0;
            tx        <= '0;
            addr_sr   <= '0;
            is_rd     <= 1'b0;
            rd_d      <= 1'b0;
            wop       <= WOP_NONE;
            extra     <= 1'b0;
            wrote     <= 1'b0;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            wel       <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rx        <= rx_nxt;
            tx        <= tx_nxt;
            addr_sr   <= addr_sr_nxt;
            is_rd     <= is_rd_nxt;
            rd_d      <= mem_rd;
            wop       <= wop_nxt;
            extra     <= extra_nxt;
            wrote     <= wrote_nxt;
            miso      <= miso_nxt;
            miso_oe   <= miso_oe_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_rd    <= mem_rd_nxt;
            mem_wr    <= mem_wr_nxt;
            mem_wdata <= mem_wdata_nxt;
            wel       <= wel_nxt;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rx_nxt        = rx;
        tx_nxt        = tx;
        addr_sr_nxt   = addr_sr;
        is_rd_nxt     = is_rd;
        wop_nxt       = wop;
        extra_nxt     = extra;
        wrote_nxt     = wrote;
        miso_nxt      = miso;
        mem_addr_nxt  = mem_addr;
        mem_rd_nxt    = 1'b0;
        mem_wr_nxt    = 1'b0;
        mem_wdata_nxt = mem_wdata;
        wel_nxt       = wel;

        // Memory returns data the cycle after the strobe
        if (rd_d) begin
            tx_nxt = mem_rdata;
        end
        // Advance only after the write strobe has been seen with its address
        if (mem_wr) begin
            mem_addr_nxt = addr_inc(mem_addr);
        end

        if (ss_rise) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            if (!extra && wop == WOP_SET) begin
                wel_nxt = 1'b1;
            end else if (!extra && wop == WOP_CLR) begin
                wel_nxt = 1'b0;
            end
            if (wrote) begin
                wel_nxt = 1'b0;
            end
            wop_nxt   = WOP_NONE;
            extra_nxt = 1'b0;
            wrote_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state_nxt = ST_CMD;
                        cnt_nxt   = '0;
                        wop_nxt   = WOP_NONE;
                        extra_nxt = 1'b0;
                        wrote_nxt = 1'b0;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        rx_nxt  = {rx[5:0], mosi_bit};
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt = '0;
                            unique case ({rx, mosi_bit})
                                OP_READ: begin
                                    state_nxt = ST_ADDR;
                                    is_rd_nxt = 1'b1;
                                end
                                OP_WRITE: begin
                                    state_nxt = wel ? ST_ADDR : ST_IGNORE;
                                    is_rd_nxt = 1'b0;
                                end
                                OP_RDSR: begin
                                    state_nxt = ST_STAT;
                                    tx_nxt    = status_byte(wel);
                                end
                                OP_WREN: begin
                                    state_nxt = ST_IGNORE;
                                    wop_nxt   = WOP_SET;
                                end
                                OP_WRDI: begin
                                    state_nxt = ST_IGNORE;
                                    wop_nxt   = WOP_CLR;
                                end
                                default: state_nxt = ST_IGNORE;
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_sr_nxt = {addr_sr[ADDR_W-3:0], mosi_bit};
                        cnt_nxt     = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(ADDR_W - 1)) begin
                            cnt_nxt      = '0;
                            mem_addr_nxt = addr_mod({addr_sr, mosi_bit});
                            mem_rd_nxt   = is_rd;
                            state_nxt    = is_rd ? ST_RDATA : ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sck_fall) begin
                        miso_nxt = tx[7];
                        tx_nxt   = {tx[6:0], 1'b0};
                    end else if (sck_rise) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        // Prefetch the next byte well before the following fall
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt      = '0;
                            mem_addr_nxt = addr_inc(mem_addr);
                            mem_rd_nxt   = 1'b1;
                        end
                    end
                end
                ST_STAT: begin
                    if (sck_fall) begin
                        miso_nxt = tx[7];
                        tx_nxt   = {tx[6:0], 1'b0};
                    end else if (sck_rise) begin
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt = '0;
                            tx_nxt  = status_byte(wel);
                        end
                    end
                end
                ST_WDATA: begin
                    if (sck_rise) begin
                        rx_nxt  = {rx[5:0], mosi_bit};
                        cnt_nxt = cnt + CNT_W'(1);
                        if (cnt == CNT_W'(7)) begin
                            cnt_nxt       = '0;
                            mem_wdata_nxt = {rx, mosi_bit};
                            mem_wr_nxt    = 1'b1;
                            wrote_nxt     = 1'b1;
                        end
                    end
                end
                ST_IGNORE: begin
                    // Any bit past the opcode voids a pending WREN/WRDI
                    if (sck_rise) begin
                        extra_nxt = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        miso_oe_nxt = (state_nxt == ST_RDATA) || (state_nxt == ST_STAT);
    end

endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Self-checking bench: SPI master tasks, behavioural EEPROM model, randomized traffic.
module tb_spi_eeprom_responder;
    import spi_eeprom_pkg::*;

    localparam int HALF = 6;   // spi_clk half period in clk cycles

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        spi_clk = 1'b0;
    logic        ss = 1'b1;
    logic        mosi = 1'b0;
    logic        miso, miso_oe, mem_rd, mem_wr, wel;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mem_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_eeprom_responder #(.ADDR_W(16), .MEM_DEPTH(65536), .SYNC_STG(2)) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .wel(wel)
    );

    // Memory attached to the DUT
    logic [7:0] mem [0:65535];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    // Reference model state
    logic [7:0] ref_mem [0:65535];
    logic       ref_wel = 1'b0;

    // Strobe monitor
    int   rd_cnt = 0, wr_cnt = 0;
    bit   overlap_seen = 0, long_seen = 0;
    logic prev_rd = 1'b0, prev_wr = 1'b0;
    always @(negedge clk) begin
        if (mem_rd) rd_cnt++;
        if (mem_wr) wr_cnt++;
        if (mem_rd && mem_wr) overlap_seen = 1;
        if ((mem_rd && prev_rd) || (mem_wr && prev_wr)) long_seen = 1;
        prev_rd = mem_rd;
        prev_wr = mem_wr;
    end

    // SPI master
    bit         mq[$];
    bit         sq[$];
    logic [7:0] wq[$];

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
    endtask

    task automatic push_addr(input logic [15:0] a);
        for (int i = 15; i >= 0; i--) mq.push_back(a[i]);
    endtask

    task automatic sel();
        mq.delete();
        sq.delete();
        ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic desel();
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic clock_bits(input int n);
        for (int i = 0; i < n; i++) begin
            mosi = (mq.size() > 0) ? mq.pop_front() : 1'b0;
            wait_clk(HALF);
            spi_clk = 1'b1;
            sq.push_back(miso);
            wait_clk(HALF);
            spi_clk = 1'b0;
        end
    endtask

    function automatic logic [7:0] sbyte(input int off);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], sq[off+i]};
        return b;
    endfunction

    task automatic send_cmd(input logic [7:0] op, input int nbits);
        sel();
        push_byte(op);
        clock_bits(nbits);
        desel();
        if (nbits == 8 && op == OP_WREN) ref_wel = 1'b1;
        if (nbits == 8 && op == OP_WRDI) ref_wel = 1'b0;
    endtask

    task automatic read_status(output logic [7:0] s0, output logic [7:0] s1);
        sel();
        push_byte(OP_RDSR);
        clock_bits(24);
        s0 = sbyte(8);
        s1 = sbyte(16);
        desel();
    endtask

    task automatic do_read(input logic [15:0] a, input int n);
        sel();
        push_byte(OP_READ);
        push_addr(a);
        clock_bits(24 + 8 * n);
    endtask

    task automatic do_write(input logic [15:0] a);
        sel();
        push_byte(OP_WRITE);
        push_addr(a);
        foreach (wq[i]) push_byte(wq[i]);
        clock_bits(24 + 8 * wq.size());
        desel();
        if (ref_wel) begin
            foreach (wq[i]) ref_mem[16'(a + i)] = wq[i];
            if (wq.size() > 0) ref_wel = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        wait_clk(4);
        checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
        checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
        checks++; if (wel !== 1'b0) begin errors++; $display("FAIL reset_wel: got %b want 0", wel); end
        reset = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_read_burst();
        int base, pulses;
        mem[16'h0010] = 8'hA5; ref_mem[16'h0010] = 8'hA5;
        mem[16'h0011] = 8'h3C; ref_mem[16'h0011] = 8'h3C;
        mem[16'h0012] = 8'hFF; ref_mem[16'h0012] = 8'hFF;
        mem[16'h0013] = 8'h00; ref_mem[16'h0013] = 8'h00;
        base = rd_cnt;
        do_read(16'h0010, 0);
        clock_bits(31);
        // Final data clock by hand: count strobes issued for the four bytes shifted
        wait_clk(HALF);
        spi_clk = 1'b1;
        sq.push_back(miso);
        pulses = rd_cnt - base;
        wait_clk(HALF);
        spi_clk = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sbyte(24 + 8 * i) !== ref_mem[16'(16'h0010 + i)]) begin
                errors++;
                $display("FAIL burst_byte%0d: got %h want %h", i, sbyte(24 + 8 * i), ref_mem[16'(16'h0010 + i)]);
            end
        end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL burst_rd_pulses: got %0d want 4", pulses); end
        checks++; if (miso_oe !== 1'b1) begin errors++; $display("FAIL burst_oe_on: got %b want 1", miso_oe); end
        desel();
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL burst_oe_off: got %b want 0", miso_oe); end
    endtask

    task automatic test_read_wrap();
        do_read(16'hFFFF, 2);
        desel();
        checks++; if (sbyte(24) !== ref_mem[16'hFFFF]) begin errors++; $display("FAIL wrap_byte0: got %h want %h", sbyte(24), ref_mem[16'hFFFF]); end
        checks++; if (sbyte(32) !== ref_mem[16'h0000]) begin errors++; $display("FAIL wrap_byte1: got %h want %h", sbyte(32), ref_mem[16'h0000]); end
    endtask

    task automatic test_write_protect();
        int base = wr_cnt;
        wq = '{8'h11, 8'h22};
        do_write(16'h0100);
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL wp_no_wr: got %0d strobes want 0", wr_cnt - base); end
        checks++; if (mem[16'h0100] !== ref_mem[16'h0100]) begin errors++; $display("FAIL wp_mem: got %h want %h", mem[16'h0100], ref_mem[16'h0100]); end
    endtask

    task automatic test_wren_write();
        int base;
        send_cmd(OP_WREN, 8);
        checks++; if (wel !== ref_wel) begin errors++; $display("FAIL wren_wel: got %b want %b", wel, ref_wel); end
        base = wr_cnt;
        wq = '{8'h11, 8'h22};
        do_write(16'h0100);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL wr_strobes: got %0d want 2", wr_cnt - base); end
        checks++; if (mem[16'h0100] !== 8'h11) begin errors++; $display("FAIL wr_mem0: got %h want 11", mem[16'h0100]); end
        checks++; if (mem[16'h0101] !== 8'h22) begin errors++; $display("FAIL wr_mem1: got %h want 22", mem[16'h0101]); end
        checks++; if (wel !== ref_wel) begin errors++; $display("FAIL wr_wel_clear: got %b want %b", wel, ref_wel); end
    endtask

    task automatic test_wel_bits();
        logic [7:0] s0, s1;
        send_cmd(OP_WREN, 7);
        checks++; if (wel !== ref_wel) begin errors++; $display("FAIL wren7_wel: got %b want %b", wel, ref_wel); end
        send_cmd(OP_WREN, 9);
        checks++; if (wel !== ref_wel) begin errors++; $display("FAIL wren9_wel: got %b want %b", wel, ref_wel); end
        send_cmd(OP_WREN, 8);
        read_status(s0, s1);
        checks++; if (s0 !== {6'b0, ref_wel, 1'b0}) begin errors++; $display("FAIL rdsr_set: got %h want %h", s0, {6'b0, ref_wel, 1'b0}); end
        checks++; if (s1 !== {6'b0, ref_wel, 1'b0}) begin errors++; $display("FAIL rdsr_repeat: got %h want %h", s1, {6'b0, ref_wel, 1'b0}); end
        send_cmd(OP_WRDI, 8);
        read_status(s0, s1);
        checks++; if (s0 !== {6'b0, ref_wel, 1'b0}) begin errors++; $display("FAIL rdsr_clr: got %h want %h", s0, {6'b0, ref_wel, 1'b0}); end
    endtask

    task automatic test_abort_write();
        int base;
        logic [7:0] s0, s1;
        send_cmd(OP_WREN, 8);
        base = wr_cnt;
        sel();
        push_byte(OP_WRITE);
        push_addr(16'h0200);
        push_byte(8'hB7);
        clock_bits(24 + 5);
        desel();
        checks++; if (wr_cnt - base !== 0) begin errors++; $display("FAIL abort_no_wr: got %0d strobes want 0", wr_cnt - base); end
        checks++; if (mem[16'h0200] !== ref_mem[16'h0200]) begin errors++; $display("FAIL abort_mem: got %h want %h", mem[16'h0200], ref_mem[16'h0200]); end
        checks++; if (wel !== ref_wel) begin errors++; $display("FAIL abort_wel: got %b want %b", wel, ref_wel); end
        read_status(s0, s1);
        checks++; if (s0 !== {6'b0, ref_wel, 1'b0}) begin errors++; $display("FAIL abort_next_cmd: got %h want %h", s0, {6'b0, ref_wel, 1'b0}); end
        send_cmd(OP_WRDI, 8);
    endtask

    task automatic test_random();
        logic [15:0] a;
        int n;
        for (int it = 0; it < 6; it++) begin
            a = (it == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
            n = $urandom_range(1, 4);
            wq.delete();
            for (int k = 0; k < n; k++) wq.push_back(8'($urandom));
            send_cmd(OP_WREN, 8);
            do_write(a);
            checks++; if (wel !== ref_wel) begin errors++; $display("FAIL rnd_wel%0d: got %b want %b", it, wel, ref_wel); end
            do_read(a, n + 1);
            desel();
            for (int k = 0; k <= n; k++) begin
                checks++;
                if (sbyte(24 + 8 * k) !== ref_mem[16'(a + k)]) begin
                    errors++;
                    $display("FAIL rnd_rd%0d_%0d: got %h want %h", it, k, sbyte(24 + 8 * k), ref_mem[16'(a + k)]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_read(16'h0010, 1);
        clock_bits(4);
        reset = 1'b0;
        ref_wel = 1'b0;
        #1;
        checks++; if (miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe: got %b want 0", miso_oe); end
        checks++; if (mem_rd !== 1'b0 || mem_wr !== 1'b0) begin errors++; $display("FAIL rstmid_strobes: got rd=%b wr=%b want 0", mem_rd, mem_wr); end
        wait_clk(3);
        spi_clk = 1'b0;
        ss = 1'b1;
        reset = 1'b1;
        wait_clk(6);
        do_read(16'h0010, 4);
        desel();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (sbyte(24 + 8 * i) !== ref_mem[16'(16'h0010 + i)]) begin
                errors++;
                $display("FAIL rstmid_rd%0d: got %h want %h", i, sbyte(24 + 8 * i), ref_mem[16'(16'h0010 + i)]);
            end
        end
    endtask

    task automatic test_strobes();
        checks++; if (overlap_seen) begin errors++; $display("FAIL strobe_overlap: got 1 want 0"); end
        checks++; if (long_seen) begin errors++; $display("FAIL strobe_width: got >1 clk want 1 clk"); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        fork
            begin
                test_reset();
                test_read_burst();
                test_read_wrap();
                test_write_protect();
                test_wren_write();
                test_wel_bits();
                test_abort_write();
                test_random();
                test_reset_mid();
                test_strobes();
            end
            begin
                #5ms;
                errors++;
                $display("FAIL timeout: simulation exceeded time budget");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
